fetch_unit: RTL and testbench

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_pkg.sv | 19 +
 rtl/fetch_fifo.sv | 68 ++++++
 rtl/fetch_unit.sv | 87 ++++++++
 tb/tb_fetch_unit.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch unit.
package fetch_pkg;

  localparam int XLEN    = 32;
  localparam int INSTR_W = 32;
  localparam logic [XLEN-1:0] PC_STEP = 32'd4;

  typedef enum logic {BOOT, RUN} fetch_state_e;

  typedef struct packed {
    logic [XLEN-1:0]    pc;
    logic [INSTR_W-1:0] instr;
  } fetch_entry_t;

  function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] a);
    return {a[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Small register FIFO with flush; pointers wrap explicitly so DEPTH need not be a power of two.
module fetch_fifo #(
  parameter  int W     = 64,
  parameter  int DEPTH = 2,
  localparam int PW    = $clog2(DEPTH),
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          flush,
  input  logic          push,
  input  logic [W-1:0]  push_data,
  input  logic          pop,
  output logic          out_valid,
  output logic [W-1:0]  out_data,
  output logic [CW-1:0] count
);

  logic [DEPTH-1:0][W-1:0] mem_q, mem_d;
  logic [PW-1:0]           wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]           count_q, count_d;
  logic                    do_push, do_pop;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign out_valid = (count_q != '0);
  assign out_data  = mem_q[rd_ptr_q];
  assign count     = count_q;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    do_pop   = pop && (count_q != '0);
    // a push into a full buffer is only legal when the head leaves the same cycle
    do_push  = push && ((count_q != CW'(DEPTH)) || do_pop);
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) begin
        mem_d[wr_ptr_q] = push_data;
        wr_ptr_d        = ptr_inc(wr_ptr_q);
      end
      if (do_pop) rd_ptr_d = ptr_inc(rd_ptr_q);
      count_d = count_q + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: credit-checked issue to a registered-read memory, responses into an output FIFO.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  output logic [31:0] out_pc,
  output logic [31:0] out_instr,
  input  logic        out_ready
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int OW = CW + 1;

  fetch_state_e    state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d, inflight_pc_q, inflight_pc_d;
  logic            inflight_q, inflight_d;
  logic [CW-1:0]   fifo_count;
  logic [OW-1:0]   occupancy;
  logic            pop, push, issue;
  fetch_entry_t    push_entry, head_entry;

  assign imem_addr = pc_q;
  assign pop       = out_valid && out_ready;
  // the response landing this cycle is squashed by a redirect
  assign push      = inflight_q && !redirect_valid;

  // credit: buffered + outstanding after this cycle's pop must leave room for one more
  assign occupancy = {1'b0, fifo_count} + OW'(inflight_q) - OW'(pop);
  assign issue     = (state_q == RUN) && !redirect_valid && (occupancy < OW'(DEPTH));

  assign push_entry = '{pc: inflight_pc_q, instr: imem_data};
  assign out_pc     = head_entry.pc;
  assign out_instr  = head_entry.instr;

  always_comb begin
    state_d       = RUN;
    pc_d          = pc_q;
    inflight_d    = 1'b0;
    inflight_pc_d = inflight_pc_q;
    if (redirect_valid) begin
      pc_d = align_pc(redirect_pc);
    end else if (issue) begin
      pc_d          = pc_q + PC_STEP;
      inflight_d    = 1'b1;
      inflight_pc_d = pc_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= BOOT;
      pc_q          <= align_pc(RESET_PC);
      inflight_q    <= 1'b0;
      inflight_pc_q <= '0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      inflight_q    <= inflight_d;
      inflight_pc_q <= inflight_pc_d;
    end
  end

  fetch_fifo #(
    .W     ($bits(fetch_entry_t)),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (redirect_valid),
    .push      (push),
    .push_data (push_entry),
    .pop       (pop),
    .out_valid (out_valid),
    .out_data  (head_entry),
    .count     (fifo_count)
  );

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench: two fetch units (default and wrapped/deeper) against a registered-read memory model.
module tb_fetch_unit;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, out_ready, redirect_valid;
  logic [31:0] redirect_pc;
  logic [31:0] imem_addr_a, imem_data_a, out_pc_a, out_instr_a;
  logic [31:0] imem_addr_b, imem_data_b, out_pc_b, out_instr_b;
  logic        out_valid_a, out_valid_b;

  fetch_unit #(.RESET_PC(32'h0000_0000), .DEPTH(2)) dut_a (
    .clk(clk), .rst_n(rst_n), .imem_addr(imem_addr_a), .imem_data(imem_data_a),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .out_valid(out_valid_a), .out_pc(out_pc_a), .out_instr(out_instr_a), .out_ready(out_ready));

  fetch_unit #(.RESET_PC(32'hFFFF_FFF8), .DEPTH(3)) dut_b (
    .clk(clk), .rst_n(rst_n), .imem_addr(imem_addr_b), .imem_data(imem_data_b),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .out_valid(out_valid_b), .out_pc(out_pc_b), .out_instr(out_instr_b), .out_ready(out_ready));

  // word at byte address a holds a>>2, so words 0..6 are 0..6
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {2'b00, a[31:2]};
  endfunction

  always @(posedge clk) begin
    imem_data_a <= mem_word(imem_addr_a);
    imem_data_b <= mem_word(imem_addr_b);
  end

  int n_cmp = 0;
  int n_bad = 0;
  int k = 0;
  int max_cnt_a = 0;
  logic [31:0] acc_pc_a[$], acc_in_a[$], acc_pc_b[$], acc_in_b[$];
  int          acc_k_a[$];

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", tag, act, exp);
    end
  endtask

  // one clock: drive inputs for the coming edge, log transfers that will happen on it
  task automatic cyc(input logic rdy, input logic rv, input logic [31:0] rpc);
    @(posedge clk); #1;
    k++;
    out_ready = rdy; redirect_valid = rv; redirect_pc = rpc;
    if (out_valid_a && rdy) begin
      acc_pc_a.push_back(out_pc_a); acc_in_a.push_back(out_instr_a); acc_k_a.push_back(k);
    end
    if (out_valid_b && rdy) begin
      acc_pc_b.push_back(out_pc_b); acc_in_b.push_back(out_instr_b);
    end
    if (int'(dut_a.u_fifo.count_q) > max_cnt_a) max_cnt_a = int'(dut_a.u_fifo.count_q);
  endtask

  task automatic do_reset();
    rst_n = 1'b0; out_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
    #1;
    chk("rst_vld_a", out_valid_a, 32'd0);
    chk("rst_pc_a", out_pc_a, 32'd0);
    chk("rst_in_a", out_instr_a, 32'd0);
    chk("rst_addr_a", imem_addr_a, 32'h0000_0000);
    chk("rst_vld_b", out_valid_b, 32'd0);
    chk("rst_addr_b", imem_addr_b, 32'hFFFF_FFF8);
    repeat (2) @(posedge clk);
    @(posedge clk); #1;
    rst_n = 1'b1;
    k = 0; max_cnt_a = 0;
    acc_pc_a.delete(); acc_in_a.delete(); acc_k_a.delete();
    acc_pc_b.delete(); acc_in_b.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  logic [31:0] wrap_pc[4];
  logic [31:0] wrap_in[4];
  logic [31:0] rd_pc[16];

  initial begin
    wrap_pc = '{32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0000_0000, 32'h0000_0004};
    wrap_in = '{32'h3FFF_FFFE, 32'h3FFF_FFFF, 32'h0000_0000, 32'h0000_0001};
    rd_pc   = '{32'h10, 32'h14, 32'h18, 32'h1C, 32'h20, 32'h24,
                32'h10, 32'h14, 32'h18, 32'h1C, 32'h20, 32'h24,
                32'h80, 32'h84, 32'h88, 32'h8C};
    rst_n = 1'b1; out_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
    #2;
    do_reset();

    // streaming, first-valid latency, wrap on the second unit
    for (int i = 1; i <= 12; i++) begin
      cyc(1'b1, 1'b0, 32'h0);
      if (k == 2) chk("lat_k2_vld", out_valid_a, 32'd0);
      if (k == 3) begin
        chk("lat_k3_vld", out_valid_a, 32'd1);
        chk("lat_k3_pc", out_pc_a, 32'h0);
      end
    end
    chk("s_cnt", acc_pc_a.size() >= 7, 32'd1);
    for (int i = 0; i < 7; i++) begin
      chk($sformatf("s_pc%0d", i), acc_pc_a[i], 32'(4 * i));
      chk($sformatf("s_in%0d", i), acc_in_a[i], 32'(i));
      chk($sformatf("s_cyc%0d", i), acc_k_a[i], 32'(3 + i));
    end
    chk("w_cnt", acc_pc_b.size() >= 4, 32'd1);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("w_pc%0d", i), acc_pc_b[i], wrap_pc[i]);
      chk($sformatf("w_in%0d", i), acc_in_b[i], wrap_in[i]);
    end

    // backpressure: ready low in cycles 5..9
    do_reset();
    for (int i = 1; i <= 25; i++) begin
      cyc(!(i >= 5 && i <= 9), 1'b0, 32'h0);
      if (k >= 5 && k <= 9) begin
        chk($sformatf("bp_hold_pc%0d", k), out_pc_a, 32'h8);
        chk($sformatf("bp_hold_vld%0d", k), out_valid_a, 32'd1);
      end
    end
    chk("bp_cnt", acc_pc_a.size(), 32'd18);
    for (int i = 0; i < acc_pc_a.size(); i++) begin
      chk($sformatf("bp_pc%0d", i), acc_pc_a[i], 32'(4 * i));
      chk($sformatf("bp_in%0d", i), acc_in_a[i], 32'(i));
    end
    chk("bp_max_le_depth", max_cnt_a <= 2, 32'd1);

    // redirects: with buffered+inflight work, misaligned with pop, back-to-back
    do_reset();
    for (int i = 1; i <= 27; i++) begin
      logic        rv;
      logic [31:0] rpc;
      rv  = (i == 4) || (i == 12) || (i == 20) || (i == 21);
      rpc = (i == 4) ? 32'h10 : (i == 12) ? 32'h13 : (i == 20) ? 32'h40 : 32'h80;
      cyc(i >= 5, rv, rpc);
      if (k == 4) begin
        chk("rd_setup_cnt", dut_b.u_fifo.count_q, 32'd2);
        chk("rd_setup_infl", dut_b.inflight_q, 32'd1);
        chk("rd_setup_pc", out_pc_b, 32'hFFFF_FFF8);
      end
      if (k == 5) begin
        chk("rd_flush_vld_a", out_valid_a, 32'd0);
        chk("rd_flush_vld_b", out_valid_b, 32'd0);
      end
      if (k == 7) begin
        chk("rd_first_vld_b", out_valid_b, 32'd1);
        chk("rd_first_pc_b", out_pc_b, 32'h10);
      end
      if (k == 13) begin
        chk("mis_addr_a", imem_addr_a, 32'h10);
        chk("mis_addr_b", imem_addr_b, 32'h10);
        chk("mis_vld_a", out_valid_a, 32'd0);
      end
      if (k == 21) chk("b2b_vld_a", out_valid_a, 32'd0);
    end
    chk("rd_cnt_a", acc_pc_a.size(), 32'd16);
    chk("rd_cnt_b", acc_pc_b.size(), 32'd16);
    for (int i = 0; i < 16; i++) begin
      chk($sformatf("rd_pc_a%0d", i), acc_pc_a[i], rd_pc[i]);
      chk($sformatf("rd_in_a%0d", i), acc_in_a[i], mem_word(rd_pc[i]));
      chk($sformatf("rd_pc_b%0d", i), acc_pc_b[i], rd_pc[i]);
    end

    // reset mid-stream while out_pc is 8
    do_reset();
    for (int i = 1; i <= 5; i++) cyc(1'b1, 1'b0, 32'h0);
    chk("mr_pc", out_pc_a, 32'h8);
    chk("mr_vld", out_valid_a, 32'd1);
    do_reset();
    for (int i = 1; i <= 6; i++) cyc(1'b1, 1'b0, 32'h0);
    chk("mr_cnt", acc_pc_a.size() >= 1, 32'd1);
    chk("mr_first_pc", acc_pc_a[0], 32'h0);
    chk("mr_first_cyc", acc_k_a[0], 32'd3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
